// File: rtl/line_buffer_k.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_k
// Purpose  : K-row line buffer that presents a vertically aligned column of
//            taps from a raster pixel stream. LINEBUF_ZPAD_EN selects top
//            zero-padding mode.
// Revision : 1.0  initial release
// ============================================================================
module line_buffer_k #(
    parameter int MAP_WIDTH   = 24,
    parameter int MAP_HEIGHT  = 24,
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_ROWS = 3,
    localparam int COL_W = (MAP_WIDTH  > 1) ? $clog2(MAP_WIDTH)  : 1,
    localparam int ROW_W = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic [DATA_WIDTH-1:0]             d_in,
    input  logic                              in_valid,
    output logic [KERNEL_ROWS*DATA_WIDTH-1:0] d_out,
    output logic                              out_valid,
    output logic [COL_W-1:0]                  col_idx,
    output logic [ROW_W-1:0]                  row_idx,
    output logic                              frame_done
);

    localparam int              c_depth     = (KERNEL_ROWS - 1) * MAP_WIDTH + 1;
    localparam logic [COL_W-1:0] c_col_last  = COL_W'(MAP_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_row_last  = ROW_W'(MAP_HEIGHT - 1);
    localparam logic [ROW_W-1:0] c_row_first = ROW_W'(KERNEL_ROWS - 1);

    logic [DATA_WIDTH-1:0]             r_sr [c_depth];
    logic [COL_W-1:0]                  r_col;
    logic [ROW_W-1:0]                  r_row;
    logic [COL_W-1:0]                  r_pix_col;
    logic [ROW_W-1:0]                  r_pix_row;
    logic                              r_acc;
    logic                              w_accept;
    logic                              w_row_ok;
    logic                              w_last;
    logic [KERNEL_ROWS*DATA_WIDTH-1:0] w_taps;

    assign w_accept = in_valid & ~clr;
    assign w_last   = (r_pix_col == c_col_last) && (r_pix_row == c_row_last);

    // Pixel storage carries no reset; row gating hides whatever it holds.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sr[0] <= d_in;
            for (int i = 1; i < c_depth; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    // Stage 1: raster position counters and position of the last accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_pix_col <= '0;
            r_pix_row <= '0;
            r_acc     <= 1'b0;
        end else if (clr) begin
            r_col <= '0;
            r_row <= '0;
            r_acc <= 1'b0;
        end else begin
            r_acc <= in_valid;
            if (in_valid) begin
                r_pix_col <= r_col;
                r_pix_row <= r_row;
                if (r_col == c_col_last) begin
                    r_col <= '0;
                    r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar j = 0; j < KERNEL_ROWS; j++) begin : g_tap
`ifdef LINEBUF_ZPAD_EN
            if (j == 0) begin : g_newest
                assign w_taps[j*DATA_WIDTH +: DATA_WIDTH] = r_sr[0];
            end else begin : g_pad
                assign w_taps[j*DATA_WIDTH +: DATA_WIDTH] =
                    (r_pix_row < ROW_W'(j)) ? '0 : r_sr[j*MAP_WIDTH];
            end
`else
            assign w_taps[j*DATA_WIDTH +: DATA_WIDTH] = r_sr[j*MAP_WIDTH];
`endif
        end
    endgenerate

`ifdef LINEBUF_ZPAD_EN
    assign w_row_ok = 1'b1;
`else
    assign w_row_ok = (r_pix_row >= c_row_first);
`endif

    // Stage 2: registered outputs; d_out and indices hold across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out      <= '0;
            out_valid  <= 1'b0;
            col_idx    <= '0;
            row_idx    <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= r_acc & w_row_ok;
            frame_done <= r_acc & w_last;
            if (r_acc) begin
                d_out   <= w_taps;
                col_idx <= r_pix_col;
                row_idx <= r_pix_row;
            end
        end
    end

endmodule
`default_nettype wire
